spi_reg_slave: RTL

Frame decoder and register-bus master that sits directly downstream of the SPI synchronizer. Consumes its clock-domain-safe strobes (`spi_reset`, `spi_read`, `spi_write`, `spi_busy`) and registered MOSI, decodes a command byte plus data word, and issues single-cycle register read/write strobes to the local register file. Returns read data on MISO, SPI mode 0, MSB first.

---
 rtl/spi_reg_slave.sv | 138 +++++++++++++
 1 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: decodes SPI command/data frames into single-cycle register bus strobes.
// Define SPI_REG_AUTOINC_EN for burst frames with an auto-incrementing address.
module spi_reg_slave #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              spi_reset,
    input  logic              spi_read,
    input  logic              spi_write,
    input  logic              spi_busy,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err
);
    localparam int CMD_W = ADDR_W + 1;
    localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] cmd_shift;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic              is_read;
    logic              tx_load;
    logic [ADDR_W:0]   cmd_next;
    logic [DATA_W-1:0] rx_next;

    assign cmd_next = {cmd_shift, mosi};
    assign rx_next  = {rx_shift, mosi};

    // Priority: frame restart, then end-of-frame, then normal bit handling.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            cmd_shift <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            is_read   <= 1'b0;
            tx_load   <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            miso_oe   <= spi_busy;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
            tx_load   <= reg_re;
`ifdef SPI_REG_AUTOINC_EN
            // Write bursts advance the address only after the strobe has used it.
            if (reg_we) begin
                reg_addr <= reg_addr + ADDR_W'(1);
            end
`endif
            if (tx_load) begin
                tx_shift <= reg_rdata;
            end

            if (spi_reset) begin
                state     <= CMD;
                bit_cnt   <= '0;
                cmd_shift <= '0;
                rx_shift  <= '0;
                tx_shift  <= '0;
                is_read   <= 1'b0;
                tx_load   <= 1'b0;
                miso      <= 1'b0;
            end else if (state != IDLE && !spi_busy) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                tx_load   <= 1'b0;
                miso      <= 1'b0;
                frame_err <= (bit_cnt != '0);
            end else begin
                case (state)
                    CMD: begin
                        if (spi_read) begin
                            if (bit_cnt == CMD_LAST) begin
                                reg_addr <= cmd_next[ADDR_W-1:0];
                                is_read  <= cmd_next[ADDR_W];
                                reg_re   <= cmd_next[ADDR_W];
                                bit_cnt  <= '0;
                                state    <= DATA;
                            end else begin
                                cmd_shift <= cmd_next[ADDR_W-1:0];
                                bit_cnt   <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (spi_read) begin
                            rx_shift <= rx_next[DATA_W-2:0];
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                if (!is_read) begin
                                    reg_we    <= 1'b1;
                                    reg_wdata <= rx_next;
                                end
`ifdef SPI_REG_AUTOINC_EN
                                if (is_read) begin
                                    reg_addr <= reg_addr + ADDR_W'(1);
                                    reg_re   <= 1'b1;
                                end
`else
                                state <= DONE;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else if (spi_write && is_read && !tx_load) begin
                            miso     <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
